// File: rtl/sobel_window_ctrl_if.sv
// Stream bundle between the pixel source, sobel_window_ctrl and the convolution unit.
// The slave modport is the controller's view; the master modport is the source/sink side.
interface sobel_window_ctrl_if #(
  parameter int PIX_W = 12
);
  logic [PIX_W-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [9*PIX_W-1:0] win_out;
  logic               win_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, win_out, win_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, win_out, win_valid
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Raster-stream 3x3 window scheduler feeding the Sobel convolution datapath.
// Build macro SOBEL_MODE_ALT_EN: mode_out alternates per frame (0 first) and sw_mode is ignored.
module sobel_window_ctrl #(
  parameter int PIX_W = 12,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sw_mode,
  output logic               mode_out,
  output logic               busy,
  output logic               frame_done,
  sobel_window_ctrl_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CW-1:0]      col_r;
  logic [RW-1:0]      row_r;
  logic [PIX_W-1:0]   lb0_r [IMG_W];
  logic [PIX_W-1:0]   lb1_r [IMG_W];
  logic [PIX_W-1:0]   win_r [9];
  logic [PIX_W-1:0]   shift_s [9];
  logic [9*PIX_W-1:0] pack_s;
  logic [9*PIX_W-1:0] win_out_r;
  logic               win_valid_r;
  logic               mode_r;
  logic               busy_r;
  logic               done_r;
  logic               mode_next_s;
  logic               in_ready_s;
  logic               acc_s;
  logic               xfer_s;
  logic               emit_s;
  logic               last_s;
  logic               start_s;

  assign in_ready_s = (state_r == RUN) && (!win_valid_r || bus.out_ready);
  assign acc_s      = bus.in_valid && in_ready_s;
  assign xfer_s     = win_valid_r && bus.out_ready;
  // Border columns/rows (and columns left over from the previous row) never emit
  assign emit_s     = acc_s && (row_r >= ROW_TWO) && (col_r >= COL_TWO);
  assign last_s     = acc_s && (row_r == ROW_LAST) && (col_r == COL_LAST);
  assign start_s    = start && (state_r == IDLE);

  assign bus.in_ready  = in_ready_s;
  assign bus.win_out   = win_out_r;
  assign bus.win_valid = win_valid_r;
  assign mode_out      = mode_r;
  assign busy          = busy_r;
  assign frame_done    = done_r;

`ifdef SOBEL_MODE_ALT_EN
  logic alt_r;

  // Frame-parity phase handed to mode_out at each accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alt_r <= 1'b0;
    end else if (start_s) begin
      alt_r <= ~alt_r;
    end else begin
      alt_r <= alt_r;
    end
  end

  assign mode_next_s = alt_r;
`else
  assign mode_next_s = sw_mode;
`endif

  // Window shifted left by one column with the incoming column at j = 2
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      shift_s[3*i]   = win_r[3*i+1];
      shift_s[3*i+1] = win_r[3*i+2];
    end
    shift_s[2] = lb1_r[col_r];
    shift_s[5] = lb0_r[col_r];
    shift_s[8] = bus.in_data;
  end

  // Pack element [i][j] at bits [(3*i+j)*PIX_W +: PIX_W]
  always_comb begin
    pack_s = {(9*PIX_W){1'b0}};
    for (int e = 0; e < 9; e++) begin
      pack_s[e*PIX_W +: PIX_W] = shift_s[e];
    end
  end

  // Frame sequencing next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DRAIN;
        else        state_s = RUN;
      end
      DRAIN: begin
        if (!win_valid_r || bus.out_ready) state_s = DONE;
        else                               state_s = DRAIN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Line buffers and shift window; their contents are qualified by the counters
  always_ff @(posedge clk) begin
    if (acc_s) begin
      lb1_r[col_r] <= lb0_r[col_r];
      lb0_r[col_r] <= bus.in_data;
      win_r        <= shift_s;
    end
  end

  // Control state, raster counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      col_r       <= {CW{1'b0}};
      row_r       <= {RW{1'b0}};
      win_out_r   <= {(9*PIX_W){1'b0}};
      win_valid_r <= 1'b0;
      mode_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN) || (state_s == DRAIN);
      done_r  <= (state_s == DONE);
      if (start_s) begin
        mode_r <= mode_next_s;
        col_r  <= {CW{1'b0}};
        row_r  <= {RW{1'b0}};
      end else if (acc_s) begin
        if (col_r == COL_LAST) begin
          col_r <= {CW{1'b0}};
          if (row_r == ROW_LAST) row_r <= {RW{1'b0}};
          else                   row_r <= row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
      // A load in the same cycle as a transfer keeps the slot full with new data
      if (emit_s) begin
        win_valid_r <= 1'b1;
        win_out_r   <= pack_s;
      end else if (xfer_s) begin
        win_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomised self-checking bench for sobel_window_ctrl on a 5x4 frame; expected
// windows are cut directly out of a stored frame image.
module tb_sobel_window_ctrl;
  localparam int PIX_W = 12;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);
  localparam int WW    = 9 * PIX_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sw_mode = 1'b0;
  logic mode_out, busy, frame_done;

  sobel_window_ctrl_if #(.PIX_W(PIX_W)) bus ();

  sobel_window_ctrl #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .start(start), .sw_mode(sw_mode),
    .mode_out(mode_out), .busy(busy), .frame_done(frame_done), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [PIX_W-1:0] pix [IMG_H][IMG_W];
  logic [WW-1:0]    exp_q [$];
  logic [WW-1:0]    got_q [$];
  logic             exp_mode = 1'b0;
  logic             alt_phase = 1'b0;
  int done_pulses, got_at_done, stall_bad, busy_bad, accepted;
  bit timed_out;

  task automatic fill_ramp();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = PIX_W'(16 * r + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = PIX_W'($urandom);
  endtask

  // Reference: one window per interior centre, in raster order
  task automatic build_expected();
    logic [WW-1:0] w;
    exp_q.delete();
    for (int r = 1; r < IMG_H - 1; r++)
      for (int c = 1; c < IMG_W - 1; c++) begin
        w = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[(3*i+j)*PIX_W +: PIX_W] = pix[r-1+i][c-1+j];
        exp_q.push_back(w);
      end
  endtask

  task automatic start_frame(input logic m);
    @(posedge clk); #1;
    start = 1'b1;
    sw_mode = m;
`ifdef SOBEL_MODE_ALT_EN
    exp_mode = alt_phase;
    alt_phase = ~alt_phase;
`else
    exp_mode = m;
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    exp_mode = 1'b0;
    alt_phase = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  // Drives one frame and records transfers; bubble/stall: 0 none, 1 pattern, 2 random
  task automatic drive_frame(input int bubble_mode, input int stall_mode,
                             input bit mid_start, input int stop_after);
    int pidx, cyc, stall_left, tail;
    bit stall_armed, prev_hold, tog, finished, mid_done;
    logic [WW-1:0] held;
    got_q.delete();
    done_pulses = 0; got_at_done = -1; stall_bad = 0; busy_bad = 0;
    accepted = 0; timed_out = 0;
    pidx = 0; cyc = 0; stall_left = 0; tail = -1;
    stall_armed = (stall_mode == 1); prev_hold = 0; tog = 1; finished = 0; mid_done = 0;
    held = '0;
    while (cyc < 2000 && !finished) begin
      @(posedge clk); #1;
      cyc++;
      if (frame_done) begin
        done_pulses++;
        got_at_done = got_q.size();
        if (busy) busy_bad++;
        if (tail < 0) tail = 3;
      end
      if (prev_hold && bus.win_valid && bus.win_out !== held) stall_bad++;
      start = 1'b0;
      if (mid_start && !mid_done && pidx == 7) begin
        start = 1'b1;
        sw_mode = 1'b0;
        mid_done = 1;
      end
      if (stall_mode == 1 && stall_armed && bus.win_valid) begin
        stall_armed = 0;
        stall_left = 5;
      end
      if (stall_mode == 2) bus.out_ready = ($urandom_range(0, 3) != 0);
      else if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else bus.out_ready = 1'b1;
      if (pidx < IMG_W * IMG_H) begin
        bus.in_data = pix[pidx / IMG_W][pidx % IMG_W];
        if (bubble_mode == 1) bus.in_valid = tog;
        else if (bubble_mode == 2) bus.in_valid = ($urandom_range(0, 1) == 1);
        else bus.in_valid = 1'b1;
        tog = ~tog;
      end else begin
        bus.in_data = PIX_W'($urandom);
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.win_valid && !bus.out_ready && bus.in_ready) stall_bad++;
      prev_hold = bus.win_valid && !bus.out_ready;
      held = bus.win_out;
      if (bus.win_valid && bus.out_ready) got_q.push_back(bus.win_out);
      if (bus.in_valid && bus.in_ready) begin
        pidx++;
        accepted++;
        if (stop_after > 0 && accepted == stop_after) finished = 1;
      end
      if (tail > 0) begin
        tail--;
        if (tail == 0) finished = 1;
      end
    end
    if (!finished) timed_out = 1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    #2;
    vectors++;
    if ({mode_out, busy, frame_done, bus.win_valid, bus.in_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {mode_out, busy, frame_done, bus.win_valid, bus.in_ready});
    end
    vectors++;
    if (bus.win_out !== '0) begin
      errors++;
      $display("FAIL reset_win_out: got %h expected 0", bus.win_out);
    end
    @(posedge clk); #3 rst = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, bus.in_ready, bus.win_valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_no_start: got %b expected 000", {busy, bus.in_ready, bus.win_valid});
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [PIX_W-1:0] first_tab [9];
    logic [WW-1:0] w;
    first_tab = '{12'h000, 12'h001, 12'h002, 12'h010, 12'h011, 12'h012, 12'h020, 12'h021, 12'h022};
    fill_ramp();
    build_expected();
    start_frame(1'b1);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    drive_frame(0, 0, 1'b0, 0);
    vectors++;
    if (got_q.size() != NWIN) begin
      errors++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), NWIN);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL basic_win%0d: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    if (got_q.size() > 0) begin
      w = got_q[0];
      for (int e = 0; e < 9; e++) begin
        vectors++;
        if (w[e*PIX_W +: PIX_W] !== first_tab[e]) begin
          errors++; $display("FAIL basic_first_e%0d: got %h expected %h", e, w[e*PIX_W +: PIX_W], first_tab[e]);
        end
      end
      w = got_q[got_q.size() - 1];
      vectors++;
      if (w[4*PIX_W +: PIX_W] !== 12'h023) begin
        errors++; $display("FAIL basic_last_centre: got %h expected 023", w[4*PIX_W +: PIX_W]);
      end
    end
    vectors++;
    if (mode_out !== exp_mode) begin errors++; $display("FAIL basic_mode: got %b expected %b", mode_out, exp_mode); end
    vectors++;
    if (done_pulses != 1 || got_at_done != NWIN || busy_bad != 0 || timed_out) begin
      errors++;
      $display("FAIL basic_done: pulses %0d after %0d windows busy_bad %0d timeout %0d, expected 1 after %0d, 0, 0",
               done_pulses, got_at_done, busy_bad, timed_out, NWIN);
    end
  endtask

  task automatic test_backpressure();
    fill_ramp();
    build_expected();
    start_frame(1'b1);
    drive_frame(0, 1, 1'b0, 0);
    vectors++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_stall: %0d stall violations, expected 0", stall_bad); end
    vectors++;
    if (got_q.size() != NWIN) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), NWIN); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL bp_win%0d: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (done_pulses != 1 || timed_out) begin
      errors++; $display("FAIL bp_done: pulses %0d timeout %0d expected 1 0", done_pulses, timed_out);
    end
  endtask

  task automatic test_bubbles();
    fill_ramp();
    build_expected();
    start_frame(1'b1);
    drive_frame(1, 0, 1'b0, 0);
    vectors++;
    if (got_q.size() != NWIN) begin errors++; $display("FAIL bub_count: got %0d expected %0d", got_q.size(), NWIN); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL bub_win%0d: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_ramp();
    build_expected();
    start_frame(1'b1);
    drive_frame(0, 0, 1'b0, 9);
    rst = 1'b0;
    #2;
    vectors++;
    if ({mode_out, busy, frame_done, bus.win_valid, bus.in_ready} !== 5'b00000 || bus.win_out !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b/%h expected 00000/0",
               {mode_out, busy, frame_done, bus.win_valid, bus.in_ready}, bus.win_out);
    end
    exp_mode = 1'b0;
    alt_phase = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy %b expected 0", busy); end
    start_frame(1'b1);
    drive_frame(0, 0, 1'b0, 0);
    vectors++;
    if (got_q.size() != NWIN || done_pulses != 1) begin
      errors++; $display("FAIL rstmid_count: got %0d windows %0d done, expected %0d 1", got_q.size(), done_pulses, NWIN);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL rstmid_win%0d: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_start_busy();
    logic m0;
    fill_ramp();
    build_expected();
    start_frame(1'b1);
    m0 = exp_mode;
    drive_frame(0, 0, 1'b1, 0);
    vectors++;
    if (mode_out !== m0) begin errors++; $display("FAIL busy_start_mode: got %b expected %b", mode_out, m0); end
    vectors++;
    if (got_q.size() != NWIN || done_pulses != 1) begin
      errors++; $display("FAIL busy_start_count: got %0d windows %0d done, expected %0d 1", got_q.size(), done_pulses, NWIN);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL busy_start_win%0d: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      fill_random();
      build_expected();
      start_frame(1'($urandom_range(0, 1)));
      drive_frame(2, 2, 1'b0, 0);
      vectors++;
      if (stall_bad != 0 || timed_out) begin
        errors++; $display("FAIL rnd%0d_stall: violations %0d timeout %0d expected 0 0", f, stall_bad, timed_out);
      end
      vectors++;
      if (got_q.size() != NWIN || done_pulses != 1) begin
        errors++; $display("FAIL rnd%0d_count: got %0d windows %0d done, expected %0d 1", f, got_q.size(), done_pulses, NWIN);
      end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
        vectors++;
        if (got_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL rnd%0d_win%0d: got %h expected %h", f, k, got_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      build_expected();
      start_frame(1'($urandom_range(0, 1)));
      vectors++;
      if (mode_out !== exp_mode) begin
        errors++; $display("FAIL b2b%0d_mode: got %b expected %b", f, mode_out, exp_mode);
      end
      drive_frame(0, 0, 1'b0, 0);
      vectors++;
      if (got_q.size() != NWIN || done_pulses != 1) begin
        errors++; $display("FAIL b2b%0d_count: got %0d windows %0d done, expected %0d 1", f, got_q.size(), done_pulses, NWIN);
      end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
        vectors++;
        if (got_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL b2b%0d_win%0d: got %h expected %h", f, k, got_q[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_start_busy();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
